// File: rtl/crubits_sync_if.sv
// ============================================================================
//  Module      : crubits_sync_if
//  Description : TI-99/4A CRU bus pins as seen by the CRU register block.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface crubits_sync_if;
    logic        ti_cru_clk;
    logic        ti_memen;
    logic        ti_ph3;
    logic [0:14] addr;
    logic        ti_cru_out;
    logic        ti_cru_in;
    logic        ti_cru_in_oe;

    modport master (
        output ti_cru_clk,
        output ti_memen,
        output ti_ph3,
        output addr,
        output ti_cru_out,
        input  ti_cru_in,
        input  ti_cru_in_oe
    );

    modport slave (
        input  ti_cru_clk,
        input  ti_memen,
        input  ti_ph3,
        input  addr,
        input  ti_cru_out,
        output ti_cru_in,
        output ti_cru_in_oe
    );
endinterface

`default_nettype wire

// File: rtl/crubits_sync.sv
// ============================================================================
//  Module      : crubits_sync
//  Description : N writable + M read-only CRU bits, all TI strobes synchronised
//                into clk; optional self-clearing pulse bits and write strobe.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module crubits_sync #(
    parameter int               NBITS      = 8,
    parameter int               NSTAT      = 4,
    parameter logic [NBITS-1:0] RESET_VAL  = '0,
    parameter logic [NBITS-1:0] PULSE_MASK = '0,
    parameter int               PULSE_LEN  = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [3:0]                         cru_base_i,
    input  logic [(NSTAT > 0 ? NSTAT : 1)-1:0] status_in_i,
    crubits_sync_if.slave                      bus,
    output logic [NBITS-1:0]                   bits_o,
    output logic                               bits_wr_stb_o,
    output logic [6:0]                         bits_wr_idx_o
);

    localparam int         c_sw    = (NSTAT > 0) ? NSTAT : 1;
    localparam logic [7:0] c_nbits = 8'(NBITS);
    localparam logic [7:0] c_ntot  = 8'(NBITS + NSTAT);
    localparam logic [7:0] c_plen  = 8'(PULSE_LEN);

    // Strobe vector bit order: {cru_clk, ph3, memen, cru_out}
    logic [3:0]      strb_s1_q, strb_s2_q, strb_s3_q;
    logic [0:14]     addr_s1_q, addr_s2_q, addr_s3_q;
    logic [c_sw-1:0] stat_s1_q, stat_s2_q;

    logic [NBITS-1:0] bits_q, bits_d;
    logic [7:0]       cnt_q [NBITS];
    logic [7:0]       cnt_d [NBITS];
    logic             stb_q, stb_d;
    logic [6:0]       wr_idx_q, wr_idx_d;
    logic             cru_in_q, cru_in_d;
    logic             oe_q, oe_d;

    logic       w_wr_fall, w_rd_fall, w_hit, w_wr_en, w_data, w_memen, w_rd_bit;
    logic [6:0] w_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            strb_s1_q <= '0;
            strb_s2_q <= '0;
            strb_s3_q <= '0;
            addr_s1_q <= '0;
            addr_s2_q <= '0;
            addr_s3_q <= '0;
            stat_s1_q <= '0;
            stat_s2_q <= '0;
        end else begin
            strb_s1_q <= {bus.ti_cru_clk, bus.ti_ph3, bus.ti_memen, bus.ti_cru_out};
            strb_s2_q <= strb_s1_q;
            strb_s3_q <= strb_s2_q;
            addr_s1_q <= bus.addr;
            addr_s2_q <= addr_s1_q;
            addr_s3_q <= addr_s2_q;
            stat_s1_q <= status_in_i;
            stat_s2_q <= stat_s1_q;
        end
    end

    // Zeroed stages can never produce a fall: s3 must first refill with a sampled 1.
    assign w_wr_fall = strb_s3_q[3] & ~strb_s2_q[3];
    assign w_rd_fall = strb_s3_q[2] & ~strb_s2_q[2];
    assign w_memen   = strb_s3_q[1];
    assign w_data    = strb_s3_q[0];
    assign w_idx     = addr_s3_q[8:14];
    assign w_hit     = (addr_s3_q[0:3] == 4'b0001) && (addr_s3_q[4:7] == cru_base_i);
    assign w_wr_en   = w_wr_fall && w_hit && ({1'b0, w_idx} < c_nbits);

    always_comb begin
        w_rd_bit = 1'b0;
        for (int i = 0; i < NBITS; i++) begin
            if (w_idx == 7'(i)) w_rd_bit = bits_q[i];
        end
        for (int j = 0; j < NSTAT; j++) begin
            if (w_idx == 7'(NBITS + j)) w_rd_bit = stat_s2_q[j];
        end
    end

    always_comb begin
        bits_d   = bits_q;
        stb_d    = w_wr_en;
        wr_idx_d = w_wr_en ? w_idx : wr_idx_q;
        cru_in_d = cru_in_q;
        oe_d     = oe_q;
        for (int i = 0; i < NBITS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (PULSE_MASK[i] && (cnt_q[i] != 8'd0)) begin
                cnt_d[i] = cnt_q[i] - 8'd1;
                if (cnt_q[i] == 8'd1) bits_d[i] = 1'b0;
            end
            // A write landing on the expiry cycle overrides the expiry
            if (w_wr_en && (w_idx == 7'(i))) begin
                bits_d[i] = w_data;
                if (PULSE_MASK[i]) cnt_d[i] = w_data ? c_plen : 8'd0;
            end
        end
        if (w_rd_fall) begin
            if (w_memen && w_hit && ({1'b0, w_idx} < c_ntot)) begin
                cru_in_d = w_rd_bit;
                oe_d     = 1'b1;
            end else begin
                cru_in_d = 1'b0;
                oe_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bits_q   <= RESET_VAL;
            stb_q    <= 1'b0;
            wr_idx_q <= '0;
            cru_in_q <= 1'b0;
            oe_q     <= 1'b0;
            for (int i = 0; i < NBITS; i++) cnt_q[i] <= '0;
        end else begin
            bits_q   <= bits_d;
            stb_q    <= stb_d;
            wr_idx_q <= wr_idx_d;
            cru_in_q <= cru_in_d;
            oe_q     <= oe_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bits_o           = bits_q;
    assign bits_wr_stb_o    = stb_q;
    assign bits_wr_idx_o    = wr_idx_q;
    assign bus.ti_cru_in    = cru_in_q;
    assign bus.ti_cru_in_oe = oe_q;

endmodule

`default_nettype wire

// File: tb/tb_crubits_sync.sv
// ============================================================================
//  Module      : tb_crubits_sync
//  Description : Scenario bench for crubits_sync with a write scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_crubits_sync;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cru_base = 4'h2;
    logic [3:0] status_in = 4'h0;
    logic [7:0] bits, bits_b;
    logic       stb, stb_b;
    logic [6:0] widx, widx_b;

    int checks = 0;
    int errors = 0;
    int st_cnt = 0;
    int st_cnt_b = 0;
    logic [7:0] sb_q[$];
    logic [7:0] mon_e;

    crubits_sync_if bus ();
    crubits_sync_if bus_b ();

    // Second instance without pulse bits sees the same bus traffic
    assign bus_b.ti_cru_clk = bus.ti_cru_clk;
    assign bus_b.ti_memen   = bus.ti_memen;
    assign bus_b.ti_ph3     = bus.ti_ph3;
    assign bus_b.addr       = bus.addr;
    assign bus_b.ti_cru_out = bus.ti_cru_out;

    crubits_sync #(.NBITS(8), .NSTAT(4), .RESET_VAL(8'h00), .PULSE_MASK(8'h01), .PULSE_LEN(16)) dut (
        .clk(clk), .reset(reset), .cru_base_i(cru_base), .status_in_i(status_in),
        .bus(bus.slave), .bits_o(bits), .bits_wr_stb_o(stb), .bits_wr_idx_o(widx));

    crubits_sync #(.NBITS(8), .NSTAT(4), .RESET_VAL(8'h00), .PULSE_MASK(8'h00), .PULSE_LEN(16)) dut_b (
        .clk(clk), .reset(reset), .cru_base_i(cru_base), .status_in_i(status_in),
        .bus(bus_b.slave), .bits_o(bits_b), .bits_wr_stb_o(stb_b), .bits_wr_idx_o(widx_b));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (stb_b) st_cnt_b++;
        if (stb) begin
            st_cnt++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe got idx=%0d required no strobe", widx);
            end else begin
                mon_e = sb_q.pop_front();
                if (widx !== mon_e[7:1] || bits[widx[2:0]] !== mon_e[0]) begin
                    errors++;
                    $display("FAIL strobe_write got idx=%0d bit=%b required idx=%0d bit=%b",
                             widx, bits[widx[2:0]], mon_e[7:1], mon_e[0]);
                end
            end
        end
    end

    function automatic logic [0:14] mk_addr(input logic [3:0] base, input logic [6:0] idx);
        mk_addr = {4'b0001, base, idx};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_op(input logic [3:0] base, input logic [6:0] idx, input logic d,
                            input int hi, input int lo);
        bus.addr       = mk_addr(base, idx);
        bus.ti_cru_out = d;
        bus.ti_cru_clk = 1'b1;
        cyc(hi);
        bus.ti_cru_clk = 1'b0;
        if (base == cru_base && idx < 7'd8) sb_q.push_back({idx, d});
        cyc(lo);
    endtask

    task automatic ph3_op(input logic [6:0] idx, input logic memen);
        bus.addr     = mk_addr(4'h2, idx);
        bus.ti_memen = memen;
        bus.ti_ph3   = 1'b1;
        cyc(3);
        bus.ti_ph3   = 1'b0;
        cyc(4);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cyc(4);
        checks += 5;
        if (bits !== 8'h00)  begin errors++; $display("FAIL rst_bits got=%h required=00", bits); end
        if (stb !== 1'b0)    begin errors++; $display("FAIL rst_stb got=%b required=0", stb); end
        if (widx !== 7'd0)   begin errors++; $display("FAIL rst_idx got=%0d required=0", widx); end
        if (bus.ti_cru_in !== 1'b0)    begin errors++; $display("FAIL rst_cru_in got=%b required=0", bus.ti_cru_in); end
        if (bus.ti_cru_in_oe !== 1'b0) begin errors++; $display("FAIL rst_oe got=%b required=0", bus.ti_cru_in_oe); end
        reset = 1'b0;
        cyc(2);
    endtask

    task automatic test_write_latency;
        bus.addr       = mk_addr(4'h2, 7'd3);
        bus.ti_cru_out = 1'b1;
        bus.ti_cru_clk = 1'b1;
        cyc(3);
        bus.ti_cru_clk = 1'b0;
        sb_q.push_back({7'd3, 1'b1});
        cyc(2);
        checks++;
        if (bits !== 8'h00) begin errors++; $display("FAIL lat_early got=%h required=00", bits); end
        cyc(1);
        checks += 2;
        if (bits !== 8'h08) begin errors++; $display("FAIL lat_third got=%h required=08", bits); end
        if (widx !== 7'd3)  begin errors++; $display("FAIL lat_idx got=%0d required=3", widx); end
        cyc(3);
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL lat_pending got=%0d required=0", sb_q.size()); end
    endtask

    task automatic test_ignored_writes;
        int s0;
        s0 = st_cnt;
        write_op(4'h3, 7'd0, 1'b1, 3, 4);
        write_op(4'h2, 7'd8, 1'b1, 3, 4);
        write_op(4'h2, 7'd100, 1'b1, 3, 4);
        checks += 2;
        if (bits !== 8'h08) begin errors++; $display("FAIL ign_bits got=%h required=08", bits); end
        if (st_cnt != s0)   begin errors++; $display("FAIL ign_strobes got=%0d required=%0d", st_cnt, s0); end
    endtask

    task automatic test_read;
        status_in = 4'b0100;
        ph3_op(7'd10, 1'b1);
        checks += 2;
        if (bus.ti_cru_in !== 1'b1)    begin errors++; $display("FAIL rd_stat_in got=%b required=1", bus.ti_cru_in); end
        if (bus.ti_cru_in_oe !== 1'b1) begin errors++; $display("FAIL rd_stat_oe got=%b required=1", bus.ti_cru_in_oe); end
        ph3_op(7'd10, 1'b0);
        checks += 2;
        if (bus.ti_cru_in !== 1'b0)    begin errors++; $display("FAIL rd_memen0_in got=%b required=0", bus.ti_cru_in); end
        if (bus.ti_cru_in_oe !== 1'b0) begin errors++; $display("FAIL rd_memen0_oe got=%b required=0", bus.ti_cru_in_oe); end
        ph3_op(7'd3, 1'b1);
        checks += 2;
        if (bus.ti_cru_in !== 1'b1)    begin errors++; $display("FAIL rd_bit3_in got=%b required=1", bus.ti_cru_in); end
        if (bus.ti_cru_in_oe !== 1'b1) begin errors++; $display("FAIL rd_bit3_oe got=%b required=1", bus.ti_cru_in_oe); end
        ph3_op(7'd12, 1'b1);
        checks++;
        if (bus.ti_cru_in_oe !== 1'b0) begin errors++; $display("FAIL rd_idx12_oe got=%b required=0", bus.ti_cru_in_oe); end
        ph3_op(7'd11, 1'b1);
        checks += 2;
        if (bus.ti_cru_in !== 1'b0)    begin errors++; $display("FAIL rd_idx11_in got=%b required=0", bus.ti_cru_in); end
        if (bus.ti_cru_in_oe !== 1'b1) begin errors++; $display("FAIL rd_idx11_oe got=%b required=1", bus.ti_cru_in_oe); end
        status_in = 4'b1000;
        cyc(6);
        checks++;
        if (bus.ti_cru_in !== 1'b0) begin errors++; $display("FAIL rd_hold got=%b required=0", bus.ti_cru_in); end
        ph3_op(7'd11, 1'b1);
        checks++;
        if (bus.ti_cru_in !== 1'b1) begin errors++; $display("FAIL rd_idx11_new got=%b required=1", bus.ti_cru_in); end
    endtask

    task automatic test_pulse;
        int ones;
        bus.addr       = mk_addr(4'h2, 7'd0);
        bus.ti_cru_out = 1'b1;
        bus.ti_cru_clk = 1'b1;
        cyc(3);
        bus.ti_cru_clk = 1'b0;
        sb_q.push_back({7'd0, 1'b1});
        ones = 0;
        for (int c = 1; c <= 30; c++) begin
            cyc(1);
            if (bits[0]) ones++;
        end
        checks++;
        if (ones != 16) begin errors++; $display("FAIL pulse_len got=%0d required=16", ones); end

        bus.ti_cru_clk = 1'b1;
        cyc(3);
        bus.ti_cru_clk = 1'b0;
        sb_q.push_back({7'd0, 1'b1});
        ones = 0;
        for (int c = 1; c <= 40; c++) begin
            cyc(1);
            if (bits[0]) ones++;
            if (c == 7) bus.ti_cru_clk = 1'b1;
            if (c == 10) begin
                bus.ti_cru_clk = 1'b0;
                sb_q.push_back({7'd0, 1'b1});
            end
        end
        checks++;
        if (ones != 26) begin errors++; $display("FAIL pulse_restart got=%0d required=26", ones); end

        bus.ti_cru_clk = 1'b1;
        cyc(3);
        bus.ti_cru_clk = 1'b0;
        sb_q.push_back({7'd0, 1'b1});
        cyc(6);
        bus.ti_cru_out = 1'b0;
        bus.ti_cru_clk = 1'b1;
        cyc(3);
        bus.ti_cru_clk = 1'b0;
        sb_q.push_back({7'd0, 1'b0});
        cyc(2);
        checks++;
        if (bits[0] !== 1'b1) begin errors++; $display("FAIL pulse_pre_clear got=%b required=1", bits[0]); end
        cyc(1);
        checks += 2;
        if (bits[0] !== 1'b0) begin errors++; $display("FAIL pulse_clear got=%b required=0", bits[0]); end
        if (bits !== 8'h08)   begin errors++; $display("FAIL pulse_others got=%h required=08", bits); end
        cyc(3);
    endtask

    task automatic test_reset_mid;
        int s0;
        ph3_op(7'd10, 1'b1);
        s0 = st_cnt;
        bus.addr       = mk_addr(4'h2, 7'd5);
        bus.ti_cru_out = 1'b1;
        bus.ti_cru_clk = 1'b1;
        cyc(2);
        reset = 1'b1;
        cyc(1);
        bus.ti_cru_clk = 1'b0;
        cyc(4);
        reset = 1'b0;
        cyc(8);
        checks += 4;
        if (bits !== 8'h00)            begin errors++; $display("FAIL mid_bits got=%h required=00", bits); end
        if (bus.ti_cru_in_oe !== 1'b0) begin errors++; $display("FAIL mid_oe got=%b required=0", bus.ti_cru_in_oe); end
        if (st_cnt != s0)              begin errors++; $display("FAIL mid_strobes got=%0d required=%0d", st_cnt, s0); end
        if (sb_q.size() != 0)          begin errors++; $display("FAIL mid_pending got=%0d required=0", sb_q.size()); end
    endtask

    task automatic test_back_to_back;
        int s0, sb0;
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(2);
        s0  = st_cnt;
        sb0 = st_cnt_b;
        for (int i = 0; i < 8; i++) write_op(4'h2, 7'(i), ~i[0], 3, 3);
        cyc(4);
        checks += 5;
        if (st_cnt - s0 != 8)    begin errors++; $display("FAIL b2b_strobes got=%0d required=8", st_cnt - s0); end
        if (st_cnt_b - sb0 != 8) begin errors++; $display("FAIL b2b_strobes_b got=%0d required=8", st_cnt_b - sb0); end
        if (bits_b !== 8'h55)    begin errors++; $display("FAIL b2b_bits got=%h required=55", bits_b); end
        if (bits[7:1] !== 7'h2A) begin errors++; $display("FAIL b2b_bits_pulse got=%h required=2a", bits[7:1]); end
        if (sb_q.size() != 0)    begin errors++; $display("FAIL b2b_pending got=%0d required=0", sb_q.size()); end
    endtask

    initial begin
        bus.ti_cru_clk = 1'b0;
        bus.ti_memen   = 1'b1;
        bus.ti_ph3     = 1'b0;
        bus.addr       = '0;
        bus.ti_cru_out = 1'b0;
        test_reset();
        test_write_latency();
        test_ignored_writes();
        test_read();
        test_pulse();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
